key_debouncer: RTL and testbench

//  Multi-channel push-button conditioner for the board I/O layer.

---
 rtl/key_debouncer.sv | 181 ++++++++++++++++++
 tb/tb_key_debouncer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// ============================================================================
//  Module   : key_debouncer
//  Brief    : Multi-key push-button conditioner: polarity normalise, 2-FF sync,
//             per-key stable-count filter, level plus press/release pulses.
//             Optional long-press pulse when KEY_LONG_PRESS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
   parameter int N_KEYS          = 5,
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter bit ACTIVE_HIGH     = 1'b1,
   parameter int LONG_CYCLES     = 100_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_rise,
   output logic [N_KEYS-1:0] key_fall,
   output logic [N_KEYS-1:0] key_long
);

   localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMING    = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_RELEASING = 2'd3
   } state_t;

   logic [N_KEYS-1:0] w_key_norm;
   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;

   // Normalised so that 1 always means pressed; reset value is the released level.
   assign w_key_norm = ACTIVE_HIGH ? key_raw : ~key_raw;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_key_norm;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar k = 0; k < N_KEYS; k++) begin : g_key
         state_t             r_state;
         state_t             w_state_nxt;
         logic [c_cnt_w-1:0] r_cnt;
         logic [c_cnt_w-1:0] w_cnt_nxt;
         logic               r_level;
         logic               w_level_nxt;
         logic               r_rise;
         logic               w_rise_nxt;
         logic               r_fall;
         logic               w_fall_nxt;
         logic               w_s;

         assign w_s = r_sync2[k];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_level <= 1'b0;
               r_rise  <= 1'b0;
               r_fall  <= 1'b0;
            end else begin
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
               r_level <= w_level_nxt;
               r_rise  <= w_rise_nxt;
               r_fall  <= w_fall_nxt;
            end
         end

         // The count reaches DEBOUNCE_CYCLES-1 at most, so it cannot wrap.
         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_s) begin
                     w_state_nxt = ST_ARMING;
                     w_cnt_nxt   = c_cnt_one;
                  end else begin
                     w_cnt_nxt   = '0;
                  end
               end
               ST_ARMING: begin
                  if (!w_s) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else if (r_cnt == c_cnt_last) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                     w_level_nxt = 1'b1;
                     w_rise_nxt  = 1'b1;
                  end else begin
                     w_cnt_nxt   = r_cnt + c_cnt_one;
                  end
               end
               ST_PRESSED: begin
                  if (!w_s) begin
                     w_state_nxt = ST_RELEASING;
                     w_cnt_nxt   = c_cnt_one;
                  end
               end
               ST_RELEASING: begin
                  if (w_s) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                  end else if (r_cnt == c_cnt_last) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_level_nxt = 1'b0;
                     w_fall_nxt  = 1'b1;
                  end else begin
                     w_cnt_nxt   = r_cnt + c_cnt_one;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_level_nxt = 1'b0;
               end
            endcase
         end

         assign key_level[k] = r_level;
         assign key_rise[k]  = r_rise;
         assign key_fall[k]  = r_fall;

`ifdef KEY_LONG_PRESS_EN
         localparam int                  c_hold_w   = $clog2(LONG_CYCLES + 1);
         localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CYCLES);
         localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_CYCLES - 1);
         localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

         logic [c_hold_w-1:0] r_hold;
         logic                r_long;

         // Saturating at LONG_CYCLES gives at most one pulse per press;
         // only a return to IDLE rearms it.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_hold <= '0;
               r_long <= 1'b0;
            end else begin
               r_long <= 1'b0;
               if (w_state_nxt == ST_IDLE) begin
                  r_hold <= '0;
               end else if (((r_state == ST_PRESSED) || (r_state == ST_RELEASING)) &&
                            (r_hold != c_hold_max)) begin
                  r_hold <= r_hold + c_hold_one;
                  r_long <= (r_hold == c_hold_pre);
               end
            end
         end

         assign key_long[k] = r_long;
`else
         assign key_long[k] = 1'b0;
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
// ============================================================================
//  Module   : tb_key_debouncer
//  Brief    : Directed self-checking bench for key_debouncer (2 keys, 4-cycle
//             filter, 20-cycle long press). Honours KEY_LONG_PRESS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_debouncer;

   localparam int N_KEYS = 2;

   logic              clk;
   logic              rst_n;
   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_rise;
   logic [N_KEYS-1:0] key_fall;
   logic [N_KEYS-1:0] key_long;

   int n_tests = 0;
   int n_fail  = 0;

   key_debouncer #(
      .N_KEYS          (N_KEYS),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_HIGH     (1'b1),
      .LONG_CYCLES     (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw   (key_raw),
      .key_level (key_level),
      .key_rise  (key_rise),
      .key_fall  (key_fall),
      .key_long  (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Watches n cycles; outputs switch at edge ev (counted from the stimulus).
   task automatic run_window(input string tag, input int n, input int ev,
                             input logic [1:0] lvl_before, input logic [1:0] lvl_after,
                             input logic [1:0] rise_ev, input logic [1:0] fall_ev);
      for (int i = 1; i <= n; i++) begin
         step();
         check({tag, "_level"}, 32'(key_level), 32'((i >= ev) ? lvl_after : lvl_before));
         check({tag, "_rise"},  32'(key_rise),  32'((i == ev) ? rise_ev : 2'b00));
         check({tag, "_fall"},  32'(key_fall),  32'((i == ev) ? fall_ev : 2'b00));
      end
   endtask

   initial begin
      logic [1:0] exp_long;
      rst_n   = 1'b0;
      key_raw = 2'b00;
      step();
      step();
      check("rst_level", 32'(key_level), 32'h0);
      check("rst_rise",  32'(key_rise),  32'h0);
      check("rst_fall",  32'(key_fall),  32'h0);
      check("rst_long",  32'(key_long),  32'h0);
      rst_n = 1'b1;
      run_window("idle", 3, 99, 2'b00, 2'b00, 2'b00, 2'b00);

      // Clean press on key 0: level and rise appear 6 edges later.
      key_raw = 2'b01;
      run_window("press", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);

      // Clean release.
      key_raw = 2'b00;
      run_window("release", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);

      // 3-cycle bounce is rejected.
      key_raw = 2'b01;
      run_window("bnc_hi", 3, 99, 2'b00, 2'b00, 2'b00, 2'b00);
      key_raw = 2'b00;
      run_window("bnc_lo", 8, 99, 2'b00, 2'b00, 2'b00, 2'b00);

      // Stable press afterwards is accepted.
      key_raw = 2'b01;
      run_window("press2", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);

      // 2-cycle dropout during release: no fall.
      key_raw = 2'b00;
      run_window("drop_lo", 2, 99, 2'b01, 2'b01, 2'b00, 2'b00);
      key_raw = 2'b01;
      run_window("drop_hi", 8, 99, 2'b01, 2'b01, 2'b00, 2'b00);
      key_raw = 2'b00;
      run_window("release2", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);

      // Both keys together.
      key_raw = 2'b11;
      run_window("simul_press", 8, 6, 2'b00, 2'b11, 2'b11, 2'b00);
      key_raw = 2'b00;
      run_window("simul_rel", 8, 6, 2'b11, 2'b00, 2'b00, 2'b11);

      // Reset while key 0 is held: outputs clear, no fall, then re-qualify.
      key_raw = 2'b01;
      run_window("pre_rst", 7, 6, 2'b00, 2'b01, 2'b01, 2'b00);
      rst_n = 1'b0;
      step();
      check("rst_mid_level", 32'(key_level), 32'h0);
      check("rst_mid_rise",  32'(key_rise),  32'h0);
      check("rst_mid_fall",  32'(key_fall),  32'h0);
      rst_n = 1'b1;
      run_window("re_rise", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);
      key_raw = 2'b00;
      run_window("re_rel", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);

      // Long hold on key 1: one long pulse 20 cycles after the rise.
      key_raw = 2'b10;
      for (int i = 1; i <= 46; i++) begin
         step();
`ifdef KEY_LONG_PRESS_EN
         exp_long = (i == 26) ? 2'b10 : 2'b00;
`else
         exp_long = 2'b00;
`endif
         check("long_level", 32'(key_level), 32'((i >= 6) ? 2'b10 : 2'b00));
         check("long_rise",  32'(key_rise),  32'((i == 6) ? 2'b10 : 2'b00));
         check("long_pulse", 32'(key_long),  32'(exp_long));
      end
      key_raw = 2'b00;
      run_window("long_rel", 8, 6, 2'b10, 2'b00, 2'b00, 2'b10);
      check("long_after", 32'(key_long), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
